cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among the functional units (ALU, multiplier, divider, load buffer). It replaces the fixed ALU-over-MUL priority in the top level. Each cycle it picks one FU holding a valid result, drives that result onto the registered CDB, and pulses the FU's read acknowledge. The ROB and every reservation station consume the CDB.

---
 rtl/cdb_arbiter_pkg.sv | 46 ++++
 rtl/cdb_arbiter_rr_priority_pick.sv | 47 ++++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//
// Shared definitions for the common data bus (CDB) arbiter and its consumers
// (ROB, reservation stations).
//
// Contents:
//   CDB_NUM_FU, CDB_DATA_WIDTH, CDB_ROB_IX_WIDTH, CDB_FU_IX_WIDTH
//       Default machine dimensions.
//   fu_e
//       Functional unit index. The position in the request vector is the
//       FU identity.
//   cdb_t
//       One broadcast on the bus, bundled so that consumers take a single
//       port.
//   rr_next()
//       Round-robin successor of an index, modulo the number of requesters.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU       = 4;
  localparam int CDB_DATA_WIDTH   = 32;
  localparam int CDB_ROB_IX_WIDTH = 3;
  localparam int CDB_FU_IX_WIDTH  = (CDB_NUM_FU > 1) ? $clog2(CDB_NUM_FU) : 1;

  typedef enum logic [CDB_FU_IX_WIDTH-1:0] {
    FU_ALU  = 0,
    FU_MUL  = 1,
    FU_DIV  = 2,
    FU_LOAD = 3
  } fu_e;

  typedef struct packed {
    logic                        valid;
    logic [CDB_ROB_IX_WIDTH-1:0] rob_ix;
    logic [CDB_DATA_WIDTH-1:0]   value;
    logic [CDB_DATA_WIDTH-1:0]   dest;
  } cdb_t;

  // The index after ix, wrapping to 0 past the last requester. This form
  // does not assume that n is a power of two.
  function automatic int rr_next(input int ix, input int n);
    return (ix + 1 >= n) ? 0 : ix + 1;
  endfunction

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//
// Combinational rotating-priority search. The search starts at ptr and walks
// upward, wrapping modulo NUM_FU. It returns the first set request bit.
//
// Ports:
//   req     [NUM_FU-1:0]    request mask (already qualified by the caller)
//   ptr     [IX_WIDTH-1:0]  highest-priority index for this search
//   found                   at least one request bit is set
//   winner  [IX_WIDTH-1:0]  index of the first request at or after ptr;
//                           0 when found is low
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int NUM_FU   = 4,
  parameter int IX_WIDTH = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]   req,
  input  logic [IX_WIDTH-1:0] ptr,
  output logic                found,
  output logic [IX_WIDTH-1:0] winner
);

  // The candidate index carries one extra bit so that ptr + i cannot
  // overflow before it is wrapped back into range.
  logic [IX_WIDTH:0] cand;

  always_comb begin
    // NOTE: every output and temporary gets a value before the loop, so no
    // path through this block leaves a variable unassigned and no latch is
    // inferred.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand = {1'b0, ptr} + (IX_WIDTH + 1)'(i);
      if (cand >= (IX_WIDTH + 1)'(NUM_FU)) begin
        cand = cand - (IX_WIDTH + 1)'(NUM_FU);
      end
      if (!found && req[cand[IX_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = cand[IX_WIDTH-1:0];
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the single common data bus. Each cycle it picks one
// functional unit that holds a result and registers that result onto the CDB.
// It also pulses a one-cycle read acknowledge back to that FU. Every output is
// registered, so no combinational path runs from an input to an output.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   valid_in        [NUM_FU]              FU k holds a result until acknowledged
//   rob_ix_in       [NUM_FU*ROB_IX_WIDTH] ROB index per FU (FU k at slice k)
//   value_in        [NUM_FU*DATA_WIDTH]   result value per FU
//   dest_in         [NUM_FU*DATA_WIDTH]   store/load address per FU
//   flush_in        ROB flush; no grant is made in a cycle where it is high
//   read_out        [NUM_FU]              one-hot acknowledge to the granted FU
//   cdb_valid_out   the bus carries a result this cycle
//   cdb_rob_ix_out  broadcast ROB index
//   cdb_value_out   broadcast value
//   cdb_dest_out    broadcast dest
//   grant_ix_out    index of the FU on the bus (debug)
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_FU       = CDB_NUM_FU,
  parameter  int DATA_WIDTH   = CDB_DATA_WIDTH,
  parameter  int ROB_IX_WIDTH = CDB_ROB_IX_WIDTH,
  localparam int IX_WIDTH     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_FU-1:0]              valid_in,
  input  logic [NUM_FU*ROB_IX_WIDTH-1:0] rob_ix_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   value_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   dest_in,
  input  logic                           flush_in,
  output logic [NUM_FU-1:0]              read_out,
  output logic                           cdb_valid_out,
  output logic [ROB_IX_WIDTH-1:0]        cdb_rob_ix_out,
  output logic [DATA_WIDTH-1:0]          cdb_value_out,
  output logic [DATA_WIDTH-1:0]          cdb_dest_out,
  output logic [IX_WIDTH-1:0]            grant_ix_out
);

  // ---------------------------------------------------------------------------
  // Split the flattened per-FU buses into arrays indexed by FU number.
  // ---------------------------------------------------------------------------
  logic [ROB_IX_WIDTH-1:0] fu_rob_ix [NUM_FU];
  logic [DATA_WIDTH-1:0]   fu_value  [NUM_FU];
  logic [DATA_WIDTH-1:0]   fu_dest   [NUM_FU];

  for (genvar k = 0; k < NUM_FU; k++) begin : g_unpack
    assign fu_rob_ix[k] = rob_ix_in[k*ROB_IX_WIDTH +: ROB_IX_WIDTH];
    assign fu_value[k]  = value_in[k*DATA_WIDTH +: DATA_WIDTH];
    assign fu_dest[k]   = dest_in[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Eligibility and pick
  // ---------------------------------------------------------------------------
  logic [IX_WIDTH-1:0] ptr;
  logic [NUM_FU-1:0]   eligible;
  logic                found;
  logic [IX_WIDTH-1:0] winner;
  logic [NUM_FU-1:0]   winner_onehot;

  // The FU that holds read_out this cycle samples it only at the coming edge,
  // so its valid is still high. Masking it stops the same result from being
  // granted twice. A flush empties the request set, so the pointer holds.
  assign eligible      = flush_in ? '0 : (valid_in & ~read_out);
  assign winner_onehot = NUM_FU'(1) << winner;

  rr_priority_pick #(
    .NUM_FU   (NUM_FU),
    .IX_WIDTH (IX_WIDTH)
  ) u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  // ---------------------------------------------------------------------------
  // Registered bus, acknowledge and pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    // NOTE: state updates use non-blocking assignments, so every register
    // here sees pre-edge values. read_out feeds the eligibility mask in this
    // way and does not race with its own update.
    if (rst_in) begin
      // NOTE: the data registers are reset as well as the control bits. The
      // outputs are defined as zero out of reset, and a broadcast that was
      // pending when reset arrived must not reappear.
      ptr            <= '0;
      read_out       <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_dest_out   <= '0;
      grant_ix_out   <= '0;
    end else begin
      cdb_valid_out <= found;
      read_out      <= found ? winner_onehot : '0;
      if (found) begin
        cdb_rob_ix_out <= fu_rob_ix[winner];
        cdb_value_out  <= fu_value[winner];
        cdb_dest_out   <= fu_dest[winner];
        grant_ix_out   <= winner;
        ptr            <= IX_WIDTH'(rr_next(int'(winner), NUM_FU));
      end
    end
  end

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. The directed scenarios use fixed
// expected values. The randomized scenario compares every cycle against a
// behavioural model: a rotating linear search over the FUs that holds a
// result, with the just-acknowledged FU excluded.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N*RW-1:0] rob_ix_bus;
  logic [N*DW-1:0] value_bus;
  logic [N*DW-1:0] dest_bus;

  logic [N-1:0]    read_out;
  logic            cdb_valid_out;
  logic [RW-1:0]   cdb_rob_ix_out;
  logic [DW-1:0]   cdb_value_out;
  logic [DW-1:0]   cdb_dest_out;
  logic [1:0]      grant_ix_out;

  // Result held by each FU
  logic [RW-1:0] fu_rob  [N];
  logic [DW-1:0] fu_val  [N];
  logic [DW-1:0] fu_dest [N];

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign rob_ix_bus[k*RW +: RW] = fu_rob[k];
    assign value_bus[k*DW +: DW]  = fu_val[k];
    assign dest_bus[k*DW +: DW]   = fu_dest[k];
  end

  // Reference model state
  int            m_ptr;
  logic [N-1:0]  m_read;
  logic          m_valid;
  logic [RW-1:0] m_rob;
  logic [DW-1:0] m_val;
  logic [DW-1:0] m_dest;
  logic [1:0]    m_grant;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .valid_in       (valid),
    .rob_ix_in      (rob_ix_bus),
    .value_in       (value_bus),
    .dest_in        (dest_bus),
    .flush_in       (flush),
    .read_out       (read_out),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_rob_ix_out (cdb_rob_ix_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_dest_out   (cdb_dest_out),
    .grant_ix_out   (grant_ix_out)
  );

  always #5 clk = ~clk;

  // The model is advanced from the pre-edge inputs. The bench then moves to
  // 1 ns after the rising edge, where it samples outputs and drives inputs.
  task automatic tick();
    int g;
    g = -1;
    if (rst) begin
      m_ptr = 0; m_read = '0; m_valid = 1'b0;
      m_rob = '0; m_val = '0; m_dest = '0; m_grant = '0;
    end else begin
      if (!flush) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (g < 0 && valid[k] && !m_read[k]) g = k;
        end
      end
      m_valid = (g >= 0);
      m_read  = '0;
      if (g >= 0) begin
        m_read[g] = 1'b1;
        m_rob     = fu_rob[g];
        m_val     = fu_val[g];
        m_dest    = fu_dest[g];
        m_grant   = 2'(g);
        m_ptr     = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_result(input int k);
    fu_rob[k]  = RW'($urandom_range(0, 7));
    fu_val[k]  = $urandom;
    fu_dest[k] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; valid = '0;
    for (int k = 0; k < N; k++) begin
      fu_rob[k] = '0; fu_val[k] = '0; fu_dest[k] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({read_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_dest_out, grant_ix_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%0b read=%b value=%h expected all zero",
               cdb_valid_out, read_out, cdb_value_out);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({read_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_dest_out, grant_ix_out} !== '0) begin
        n_errors++;
        $display("FAIL idle_cycle_%0d: got valid=%0b read=%b grant=%0d expected all zero",
                 c, cdb_valid_out, read_out, grant_ix_out);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_request();
    do_reset();
    fu_rob[0] = 3'd3; fu_val[0] = 32'h0000_002A; fu_dest[0] = 32'h0000_1000;
    valid = 4'b0001;
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b1 || read_out !== 4'b0001 || grant_ix_out !== 2'd0) begin
      n_errors++;
      $display("FAIL single_grant: got valid=%0b read=%b grant=%0d expected 1 0001 0",
               cdb_valid_out, read_out, grant_ix_out);
    end
    n_checks++;
    if (cdb_rob_ix_out !== 3'd3 || cdb_value_out !== 32'd42 || cdb_dest_out !== 32'h1000) begin
      n_errors++;
      $display("FAIL single_data: got rob=%0d value=%0d dest=%h expected 3 42 1000",
               cdb_rob_ix_out, cdb_value_out, cdb_dest_out);
    end
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b0 || read_out !== 4'b0000 || cdb_value_out !== 32'd42) begin
      n_errors++;
      $display("FAIL single_masked: got valid=%0b read=%b value=%0d expected 0 0000 42 (held)",
               cdb_valid_out, read_out, cdb_value_out);
    end
    valid = 4'b0000;
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b0 || read_out !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_dropped: got valid=%0b read=%b expected 0 0000", cdb_valid_out, read_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [N-1:0]  prev;
    logic [DW-1:0] exp_val;
    do_reset();
    for (int k = 0; k < N; k++) begin
      fu_val[k] = 32'(100 + k); fu_rob[k] = 3'(k);
    end
    valid = '1;
    for (int i = 0; i < 12; i++) begin
      prev    = m_read;
      exp_val = fu_val[i % N];
      tick();
      n_checks++;
      if (cdb_valid_out !== 1'b1 || grant_ix_out !== 2'(i % N) || read_out !== 4'(1 << (i % N))) begin
        n_errors++;
        $display("FAIL rr_order_%0d: got valid=%0b grant=%0d read=%b expected 1 %0d %b",
                 i, cdb_valid_out, grant_ix_out, read_out, i % N, 4'(1 << (i % N)));
      end
      n_checks++;
      if (cdb_value_out !== exp_val) begin
        n_errors++;
        $display("FAIL rr_value_%0d: got %h expected %h", i, cdb_value_out, exp_val);
      end
      for (int k = 0; k < N; k++) if (prev[k]) new_result(k);
    end
    valid = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_reset();
    fu_val[1] = 32'd5; fu_rob[1] = 3'd1;
    valid = 4'b0010;
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b1 || cdb_value_out !== 32'd5 || read_out !== 4'b0010 || grant_ix_out !== 2'd1) begin
      n_errors++;
      $display("FAIL b2b_first: got valid=%0b value=%0d read=%b grant=%0d expected 1 5 0010 1",
               cdb_valid_out, cdb_value_out, read_out, grant_ix_out);
    end
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b0 || read_out !== 4'b0000) begin
      n_errors++;
      $display("FAIL b2b_gap: got valid=%0b read=%b expected 0 0000", cdb_valid_out, read_out);
    end
    fu_val[1] = 32'd6; fu_rob[1] = 3'd2;
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b1 || cdb_value_out !== 32'd6 || cdb_rob_ix_out !== 3'd2) begin
      n_errors++;
      $display("FAIL b2b_second: got valid=%0b value=%0d rob=%0d expected 1 6 2",
               cdb_valid_out, cdb_value_out, cdb_rob_ix_out);
    end
    valid = '0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    fu_val[0] = 32'd11; fu_val[2] = 32'd33;
    valid = 4'b0101;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (cdb_valid_out !== 1'b0 || read_out !== 4'b0000) begin
      n_errors++;
      $display("FAIL flush_suppress: got valid=%0b read=%b expected 0 0000", cdb_valid_out, read_out);
    end
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b1 || grant_ix_out !== 2'd0 || read_out !== 4'b0001 || cdb_value_out !== 32'd11) begin
      n_errors++;
      $display("FAIL flush_then_alu: got valid=%0b grant=%0d read=%b value=%0d expected 1 0 0001 11",
               cdb_valid_out, grant_ix_out, read_out, cdb_value_out);
    end
    tick();
    n_checks++;
    if (cdb_valid_out !== 1'b1 || grant_ix_out !== 2'd2 || read_out !== 4'b0100 || cdb_value_out !== 32'd33) begin
      n_errors++;
      $display("FAIL flush_then_div: got valid=%0b grant=%0d read=%b value=%0d expected 1 2 0100 33",
               cdb_valid_out, grant_ix_out, read_out, cdb_value_out);
    end
    valid = '0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_grant();
    do_reset();
    for (int k = 0; k < N; k++) fu_val[k] = 32'(200 + k);
    valid = '1;
    tick();
    n_checks++;
    if (grant_ix_out !== 2'd0 || cdb_valid_out !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_grant: got grant=%0d valid=%0b expected 0 1", grant_ix_out, cdb_valid_out);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (read_out !== 4'b0000 || cdb_valid_out !== 1'b0 || cdb_value_out !== 32'd0 || grant_ix_out !== 2'd0) begin
      n_errors++;
      $display("FAIL midrst_cleared: got read=%b valid=%0b value=%0d grant=%0d expected 0000 0 0 0",
               read_out, cdb_valid_out, cdb_value_out, grant_ix_out);
    end
    // FU0 sampled its acknowledge at the reset edge and moves on to a new result.
    fu_val[0] = 32'd250;
    rst = 1'b0;
    tick();
    n_checks++;
    if (grant_ix_out !== 2'd0 || read_out !== 4'b0001 || cdb_value_out !== 32'd250) begin
      n_errors++;
      $display("FAIL midrst_ptr: got grant=%0d read=%b value=%0d expected 0 0001 250",
               grant_ix_out, read_out, cdb_value_out);
    end
    valid = '0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [N-1:0] prev;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      prev  = m_read;
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (cdb_valid_out !== m_valid || read_out !== m_read) begin
        n_errors++;
        $display("FAIL rand_ctrl_%0d: got valid=%0b read=%b expected %0b %b",
                 c, cdb_valid_out, read_out, m_valid, m_read);
      end
      n_checks++;
      if (grant_ix_out !== m_grant || cdb_rob_ix_out !== m_rob ||
          cdb_value_out !== m_val || cdb_dest_out !== m_dest) begin
        n_errors++;
        $display("FAIL rand_data_%0d: got grant=%0d rob=%0d value=%h dest=%h expected %0d %0d %h %h",
                 c, grant_ix_out, cdb_rob_ix_out, cdb_value_out, cdb_dest_out,
                 m_grant, m_rob, m_val, m_dest);
      end
      // FU behaviour: an acknowledged FU drops valid or presents its next
      // result. An idle FU sometimes raises a new one.
      for (int k = 0; k < N; k++) begin
        if (prev[k]) begin
          if ($urandom_range(0, 1) == 0) valid[k] = 1'b0;
          else new_result(k);
        end else if (!valid[k] && $urandom_range(0, 2) == 0) begin
          new_result(k);
          valid[k] = 1'b1;
        end
      end
    end
    rst = 1'b0; flush = 1'b0; valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_back_to_back();
    test_flush();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cdb_arbiter
